timer_ctrl: RTL and testbench

Memory-mapped timer controller that sequences a free-running prescaler and a compare counter, and exposes both through a small register file on the core's peripheral bus. It produces a per-expiry pulse and a level interrupt to the interrupt controller, in periodic or one-shot mode. It is the software-visible owner of counter timing: software writes prescale, compare and control, and the block decides when the counter advances, wraps, stops and signals.

---
 rtl/timer_pkg.sv | 19 +
 rtl/timer_prescaler.sv | 27 ++
 rtl/timer_ctrl.sv | 107 ++++++++++
 tb/tb_timer_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared register map, bit positions and state encodings for the timer controller.
package timer_pkg;

    localparam logic [2:0] TIMER_CTRL   = 3'd0;
    localparam logic [2:0] TIMER_PRESC  = 3'd1;
    localparam logic [2:0] TIMER_CMP    = 3'd2;
    localparam logic [2:0] TIMER_VALUE  = 3'd3;
    localparam logic [2:0] TIMER_STATUS = 3'd4;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_MODE      = 1;
    localparam int CTRL_IRQ_EN    = 2;
    localparam int STATUS_PENDING = 0;
    localparam int STATUS_RUNNING = 1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler: counts 0..presc while running and emits a tick on the wrap cycle.
module timer_prescaler #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     clear,
    input  logic [COUNTER_WIDTH-1:0] presc,
    output logic                     tick
);

    logic [COUNTER_WIDTH-1:0] presc_cnt;

    assign tick = run && (presc_cnt == presc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt <= '0;
        end else if (clear || tick) begin
            presc_cnt <= '0;
        end else if (run) begin
            presc_cnt <= presc_cnt + COUNTER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Memory-mapped timer: register file, compare counter and run/idle control around the prescaler.
module timer_ctrl #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        expire_pulse
);

    import timer_pkg::*;

    logic [2:0]               ctrl;
    logic [COUNTER_WIDTH-1:0] presc;
    logic [COUNTER_WIDTH-1:0] cmp;
    logic [COUNTER_WIDTH-1:0] value;
    logic                     pending;
    logic                     state;

    logic wr_ctrl, wr_presc, wr_cmp, wr_value, wr_status;
    logic running, start, stop_wr, tick, count_en, expiry, oneshot_stop;
    logic unused_wdata;

    assign wr_ctrl   = we && (addr == TIMER_CTRL);
    assign wr_presc  = we && (addr == TIMER_PRESC);
    assign wr_cmp    = we && (addr == TIMER_CMP);
    assign wr_value  = we && (addr == TIMER_VALUE);
    assign wr_status = we && (addr == TIMER_STATUS);

    assign running = (state == ST_RUN);
    assign start   = wr_ctrl && wdata[CTRL_EN] && !running;
    assign stop_wr = wr_ctrl && !wdata[CTRL_EN];

    // A VALUE write or a software stop on the tick edge swallows that tick entirely.
    assign count_en     = tick && !wr_value && !stop_wr;
    assign expiry       = count_en && (value == cmp);
    assign oneshot_stop = expiry && ctrl[CTRL_MODE];

    assign irq          = pending && ctrl[CTRL_IRQ_EN];
    assign unused_wdata = ^wdata;

    timer_prescaler #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .run  (running),
        .clear(start || wr_value),
        .presc(presc),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl         <= '0;
            presc        <= '0;
            cmp          <= '0;
            value        <= '0;
            pending      <= 1'b0;
            state        <= ST_IDLE;
            expire_pulse <= 1'b0;
        end else begin
            // Software CTRL writes take priority over the one-shot auto-stop.
            if (wr_ctrl) begin
                ctrl  <= wdata[2:0];
                state <= wdata[CTRL_EN] ? ST_RUN : ST_IDLE;
            end else if (oneshot_stop) begin
                ctrl[CTRL_EN] <= 1'b0;
                state         <= ST_IDLE;
            end

            if (wr_presc) presc <= wdata[COUNTER_WIDTH-1:0];
            if (wr_cmp)   cmp   <= wdata[COUNTER_WIDTH-1:0];

            if (wr_value || expiry) begin
                value <= '0;
            end else if (count_en) begin
                value <= value + COUNTER_WIDTH'(1);
            end

            if (expiry) begin
                pending <= 1'b1;
            end else if (wr_status && wdata[STATUS_PENDING]) begin
                pending <= 1'b0;
            end

            expire_pulse <= expiry;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            TIMER_CTRL:   rdata = {29'd0, ctrl};
            TIMER_PRESC:  rdata = 32'(presc);
            TIMER_CMP:    rdata = 32'(cmp);
            TIMER_VALUE:  rdata = 32'(value);
            TIMER_STATUS: rdata = {30'd0, running, pending};
            default:      rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios plus randomized periodic runs vs an arithmetic model.
module tb_timer_ctrl;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_PRESC  = 3'd1;
    localparam logic [2:0] A_CMP    = 3'd2;
    localparam logic [2:0] A_VALUE  = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  addr_a, addr_b;
    logic        we_a, we_b;
    logic [31:0] wdata_a, wdata_b, rdata_a, rdata_b;
    logic        irq_a, irq_b, pulse_a, pulse_b;

    int checks = 0;
    int passes = 0;
    int pulses_a = 0;

    always #5 clk = ~clk;

    timer_ctrl #(.COUNTER_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .addr(addr_a), .we(we_a), .wdata(wdata_a),
        .rdata(rdata_a), .irq(irq_a), .expire_pulse(pulse_a)
    );

    timer_ctrl #(.COUNTER_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .addr(addr_b), .we(we_b), .wdata(wdata_b),
        .rdata(rdata_b), .irq(irq_b), .expire_pulse(pulse_b)
    );

    always @(negedge clk) if (pulse_a === 1'b1) pulses_a++;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit sel, input logic [2:0] a, input logic [31:0] d);
        if (sel) begin addr_b = a; wdata_b = d; we_b = 1'b1; end
        else     begin addr_a = a; wdata_a = d; we_a = 1'b1; end
        @(posedge clk);
        #1;
        we_a = 1'b0;
        we_b = 1'b0;
    endtask

    task automatic rd(input bit sel, input logic [2:0] a, output logic [31:0] d);
        if (sel) addr_b = a; else addr_a = a;
        #1;
        d = sel ? rdata_b : rdata_a;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        reset = 1'b1;
        we_a = 0; we_b = 0; addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
        step(2);
        for (int a = 0; a < 8; a++) begin
            rd(0, a[2:0], r);
            checks++; if (r !== 32'd0) $display("FAIL reset_reg%0d got %h want 0", a, r); else passes++;
        end
        checks++; if (irq_a !== 1'b0) $display("FAIL reset_irq got %b want 0", irq_a); else passes++;
        checks++; if (pulse_a !== 1'b0) $display("FAIL reset_pulse got %b want 0", pulse_a); else passes++;
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_periodic();
        logic [31:0] r;
        do_reset();
        wr(0, A_PRESC, 0); wr(0, A_CMP, 3); wr(0, A_CTRL, 32'b101);
        for (int k = 1; k <= 3; k++) begin
            step(1); rd(0, A_VALUE, r);
            checks++; if (r !== k) $display("FAIL periodic_value got %0d want %0d", r, k); else passes++;
        end
        step(1); rd(0, A_VALUE, r);
        checks++; if (r !== 0) $display("FAIL periodic_wrap got %0d want 0", r); else passes++;
        rd(0, A_STATUS, r);
        checks++; if (r !== 3) $display("FAIL periodic_status got %0d want 3", r); else passes++;
        checks++; if (irq_a !== 1'b1) $display("FAIL periodic_irq got %b want 1", irq_a); else passes++;
        checks++; if (pulse_a !== 1'b1) $display("FAIL periodic_pulse got %b want 1", pulse_a); else passes++;
        step(1); rd(0, A_VALUE, r);
        checks++; if (pulse_a !== 1'b0) $display("FAIL periodic_pulse_len got %b want 0", pulse_a); else passes++;
        checks++; if (irq_a !== 1'b1) $display("FAIL periodic_irq_hold got %b want 1", irq_a); else passes++;
        checks++; if (r !== 1) $display("FAIL periodic_restart got %0d want 1", r); else passes++;
        for (int p = 0; p < 2; p++) begin
            step(p == 0 ? 3 : 4); rd(0, A_VALUE, r);
            checks++; if (r !== 0 || pulse_a !== 1'b1)
                $display("FAIL periodic_repeat value %0d pulse %b want 0 1", r, pulse_a); else passes++;
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] r;
        do_reset();
        wr(0, A_PRESC, 2); wr(0, A_CMP, 1); wr(0, A_CTRL, 32'b011);
        step(5); rd(0, A_VALUE, r);
        checks++; if (r !== 1) $display("FAIL oneshot_mid got %0d want 1", r); else passes++;
        rd(0, A_STATUS, r);
        checks++; if (r !== 2 || pulse_a !== 1'b0) $display("FAIL oneshot_pre status %0d pulse %b want 2 0", r, pulse_a); else passes++;
        step(1); rd(0, A_VALUE, r);
        checks++; if (r !== 0) $display("FAIL oneshot_value got %0d want 0", r); else passes++;
        rd(0, A_STATUS, r);
        checks++; if (r !== 1) $display("FAIL oneshot_status got %0d want 1", r); else passes++;
        rd(0, A_CTRL, r);
        checks++; if (r !== 2) $display("FAIL oneshot_ctrl got %0d want 2", r); else passes++;
        checks++; if (pulse_a !== 1'b1 || irq_a !== 1'b0) $display("FAIL oneshot_pulse pulse %b irq %b want 1 0", pulse_a, irq_a); else passes++;
        step(5); rd(0, A_VALUE, r);
        checks++; if (r !== 0) $display("FAIL oneshot_stopped got %0d want 0", r); else passes++;
        rd(0, A_STATUS, r);
        checks++; if (r !== 1 || irq_a !== 1'b0 || pulse_a !== 1'b0)
            $display("FAIL oneshot_after status %0d irq %b pulse %b want 1 0 0", r, irq_a, pulse_a); else passes++;
    endtask

    task automatic test_pause();
        logic [31:0] r;
        do_reset();
        wr(0, A_PRESC, 1); wr(0, A_CMP, 9); wr(0, A_CTRL, 32'b001);
        step(4); rd(0, A_VALUE, r);
        checks++; if (r !== 2) $display("FAIL pause_start got %0d want 2", r); else passes++;
        wr(0, A_CTRL, 0);
        for (int i = 0; i < 10; i++) begin
            rd(0, A_VALUE, r);
            checks++; if (r !== 2) $display("FAIL pause_hold cycle %0d got %0d want 2", i, r); else passes++;
            step(1);
        end
        wr(0, A_CTRL, 32'b001);
        step(1); rd(0, A_VALUE, r);
        checks++; if (r !== 2) $display("FAIL pause_resume_early got %0d want 2", r); else passes++;
        step(1); rd(0, A_VALUE, r);
        checks++; if (r !== 3) $display("FAIL pause_resume got %0d want 3", r); else passes++;
    endtask

    task automatic test_w1c_collision();
        logic [31:0] r;
        do_reset();
        wr(0, A_PRESC, 0); wr(0, A_CMP, 3); wr(0, A_CTRL, 32'b101);
        step(3);
        wr(0, A_STATUS, 1);
        rd(0, A_STATUS, r);
        checks++; if (r !== 3 || irq_a !== 1'b1) $display("FAIL w1c_set_wins status %0d irq %b want 3 1", r, irq_a); else passes++;
        wr(0, A_STATUS, 1);
        rd(0, A_STATUS, r);
        checks++; if (r !== 2 || irq_a !== 1'b0) $display("FAIL w1c_clear status %0d irq %b want 2 0", r, irq_a); else passes++;
    endtask

    task automatic test_collisions();
        logic [31:0] r;
        do_reset();
        wr(0, A_PRESC, 0); wr(0, A_CMP, 0); wr(0, A_CTRL, 32'b001);
        step(1);
        checks++; if (pulse_a !== 1'b1) $display("FAIL cmp0_pulse got %b want 1", pulse_a); else passes++;
        wr(0, A_VALUE, 0);
        checks++; if (pulse_a !== 1'b0) $display("FAIL value_clear_wins got %b want 0", pulse_a); else passes++;
        step(1);
        checks++; if (pulse_a !== 1'b1) $display("FAIL cmp0_again got %b want 1", pulse_a); else passes++;
        wr(0, A_CTRL, 0);
        rd(0, A_STATUS, r);
        checks++; if (pulse_a !== 1'b0 || r !== 1) $display("FAIL stop_suppress pulse %b status %0d want 0 1", pulse_a, r); else passes++;
    endtask

    task automatic test_wrap();
        logic [31:0] r;
        do_reset();
        wr(1, A_PRESC, 0); wr(1, A_CMP, 7); wr(1, A_CTRL, 32'b001);
        step(5); rd(1, A_VALUE, r);
        checks++; if (r !== 5) $display("FAIL wrap_start got %0d want 5", r); else passes++;
        wr(1, A_CMP, 1);
        for (int i = 1; i <= 11; i++) begin
            step(1); rd(1, A_VALUE, r);
            checks++; if (r !== (6 + i) % 16 || pulse_b !== 1'b0)
                $display("FAIL wrap_count got %0d pulse %b want %0d 0", r, pulse_b, (6 + i) % 16); else passes++;
        end
        step(1); rd(1, A_VALUE, r);
        checks++; if (r !== 0 || pulse_b !== 1'b1) $display("FAIL wrap_expiry value %0d pulse %b want 0 1", r, pulse_b); else passes++;
        rd(1, A_STATUS, r);
        checks++; if (r !== 3) $display("FAIL wrap_status got %0d want 3", r); else passes++;
    endtask

    task automatic test_random();
        logic [31:0] r;
        int p, c, n, t, base, ien, exp_v, exp_pend, exp_p;
        do_reset();
        for (int it = 0; it < 6; it++) begin
            p   = $urandom_range(0, 3);
            c   = $urandom_range(0, 5);
            n   = $urandom_range(1, 40);
            ien = $urandom_range(0, 1);
            wr(0, A_CTRL, 0); wr(0, A_VALUE, 0); wr(0, A_STATUS, 1);
            wr(0, A_PRESC, p); wr(0, A_CMP, c);
            base = pulses_a;
            wr(0, A_CTRL, (ien << 2) | 1);
            step(n);
            t        = (c + 1) * (p + 1);
            exp_v    = (n / (p + 1)) % (c + 1);
            exp_pend = (n >= t) ? 1 : 0;
            exp_p    = (n - 1) / t;
            rd(0, A_VALUE, r);
            checks++; if (r !== exp_v) $display("FAIL rand_value p=%0d c=%0d n=%0d got %0d want %0d", p, c, n, r, exp_v); else passes++;
            rd(0, A_STATUS, r);
            checks++; if (r !== 2 + exp_pend) $display("FAIL rand_status n=%0d got %0d want %0d", n, r, 2 + exp_pend); else passes++;
            checks++; if (irq_a !== 1'(exp_pend & ien)) $display("FAIL rand_irq got %b want %0d", irq_a, exp_pend & ien); else passes++;
            checks++; if (pulses_a - base !== exp_p) $display("FAIL rand_pulses got %0d want %0d", pulses_a - base, exp_p); else passes++;
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] r;
        do_reset();
        wr(0, A_PRESC, 0); wr(0, A_CMP, 9); wr(0, A_CTRL, 32'b101);
        step(3); rd(0, A_VALUE, r);
        checks++; if (r !== 3) $display("FAIL areset_pre got %0d want 3", r); else passes++;
        #1;
        reset = 1'b1;
        #1;
        rd(0, A_VALUE, r);
        checks++; if (r !== 0) $display("FAIL areset_value got %0d want 0", r); else passes++;
        rd(0, A_CTRL, r);
        checks++; if (r !== 0 || irq_a !== 1'b0) $display("FAIL areset_ctrl ctrl %0d irq %b want 0 0", r, irq_a); else passes++;
        step(1);
        reset = 1'b0;
        step(4); rd(0, A_VALUE, r);
        checks++; if (r !== 0) $display("FAIL areset_idle got %0d want 0", r); else passes++;
        rd(0, A_STATUS, r);
        checks++; if (r !== 0) $display("FAIL areset_status got %0d want 0", r); else passes++;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_pause();
        test_w1c_collision();
        test_collisions();
        test_wrap();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
